// File: rtl/flash_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// flash_cmd_sequencer
//
// Write-command sequencer sitting between the CPU bus and the PRG flash
// write-enable. It follows JEDEC program / erase unlock sequences
// (AA@555, 55@2AA, command) written into $8000-$FFFF.
//
// It passes a flash write only when that write is a legitimate next step of
// such a sequence, or is the F0 reset command. Ordinary mapper-register writes
// into ROM space therefore never reach the flash.
//
// Once the final command or data byte is accepted, it times the
// program/erase busy window. A broken sequence raises a sticky error flag.
//
// Parameters
//   PROG_CYCLES    : m2 cycles busy stays high after a program data write
//   ERASE_CYCLES   : m2 cycles busy stays high after a sector/chip erase
//   TIMEOUT_CYCLES : idle m2 cycles before a partial sequence is dropped
//                    (only meaningful with FLASH_SEQ_TIMEOUT_EN)
//
// Optional feature
//   FLASH_SEQ_TIMEOUT_EN : when defined, a partial unlock/command sequence
//                          that sees no ROM write for TIMEOUT_CYCLES cycles
//                          is abandoned (state back to IDLE, error flag
//                          untouched). When undefined, partial sequences
//                          persist and the idle counter does not exist.
//
// Ports
//   m2                in   bus clock, all state changes on its rising edge
//   reset             in   synchronous, active-high
//   romsel            in   low = $8000-$FFFF access
//   cpu_rw_in         in   low = write
//   cpu_addr_in[14:0] in   CPU address; [11:0] compared with 555 / 2AA
//   cpu_data_in[7:0]  in   CPU write data
//   prg_write_enabled in   global flash-write permission from mapper config
//   flash_we_allow    out  combinational; current write may assert flash_we
//   busy              out  registered; program/erase in progress
//   seq_error         out  registered; sticky sequence-error flag
//   state_dbg[2:0]    out  current state encoding
// -----------------------------------------------------------------------------
module flash_cmd_sequencer #(
  parameter int PROG_CYCLES    = 32,
  parameter int ERASE_CYCLES   = 1000000,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        m2,
  input  logic        reset,
  input  logic        romsel,
  input  logic        cpu_rw_in,
  input  logic [14:0] cpu_addr_in,
  input  logic [7:0]  cpu_data_in,
  input  logic        prg_write_enabled,
  output logic        flash_we_allow,
  output logic        busy,
  output logic        seq_error,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_UNL1 = 3'd1,
    ST_UNL2 = 3'd2,
    ST_PROG = 3'd3,
    ST_ERA1 = 3'd4,
    ST_ERA2 = 3'd5,
    ST_ERA3 = 3'd6,
    ST_BUSY = 3'd7
  } state_t;

  // Busy counter load values. The counter is loaded with N-1 and the FSM
  // leaves BUSY on the edge after it reads 0, giving exactly N busy cycles.
  localparam logic [19:0] PROG_LOAD  = 20'(PROG_CYCLES - 1);
  localparam logic [19:0] ERASE_LOAD = 20'(ERASE_CYCLES - 1);

  localparam logic [7:0] CMD_AA    = 8'hAA;
  localparam logic [7:0] CMD_55    = 8'h55;
  localparam logic [7:0] CMD_PROG  = 8'hA0;
  localparam logic [7:0] CMD_ERASE = 8'h80;
  localparam logic [7:0] CMD_SECT  = 8'h30;
  localparam logic [7:0] CMD_CHIP  = 8'h10;
  localparam logic [7:0] CMD_RESET = 8'hF0;

  state_t      state;
  logic [19:0] busy_cnt;

  logic   rom_wr;
  logic   at_555;
  logic   at_2aa;
  logic   cmd_f0;
  logic   step_ok;
  state_t step_next;
  logic   timeout_hit;

  // The bank-select bits above A11 play no part in JEDEC command decode.
  logic unused_addr_hi;
  assign unused_addr_hi = ^cpu_addr_in[14:12];

  assign rom_wr = ~romsel & ~cpu_rw_in;
  assign at_555 = (cpu_addr_in[11:0] == 12'h555);
  assign at_2aa = (cpu_addr_in[11:0] == 12'h2AA);

  // F0 is honoured in every state except BUSY. It takes priority over the
  // step decode, so an F0 can never also be counted as a sequence error.
  assign cmd_f0 = (cpu_data_in == CMD_RESET) && (state != ST_BUSY);

  // Decode whether the data/address on the bus is the valid next step from
  // the current state, and where it leads.
  always_comb begin
    step_ok   = 1'b0;
    step_next = ST_IDLE;
    case (state)
      ST_IDLE: begin
        if (at_555 && cpu_data_in == CMD_AA) begin
          step_ok   = 1'b1;
          step_next = ST_UNL1;
        end
      end
      ST_UNL1: begin
        if (at_2aa && cpu_data_in == CMD_55) begin
          step_ok   = 1'b1;
          step_next = ST_UNL2;
        end
      end
      ST_UNL2: begin
        if (at_555 && cpu_data_in == CMD_PROG) begin
          step_ok   = 1'b1;
          step_next = ST_PROG;
        end else if (at_555 && cpu_data_in == CMD_ERASE) begin
          step_ok   = 1'b1;
          step_next = ST_ERA1;
        end
      end
      ST_PROG: begin
        // Program data: any address, any byte.
        step_ok   = 1'b1;
        step_next = ST_BUSY;
      end
      ST_ERA1: begin
        if (at_555 && cpu_data_in == CMD_AA) begin
          step_ok   = 1'b1;
          step_next = ST_ERA2;
        end
      end
      ST_ERA2: begin
        if (at_2aa && cpu_data_in == CMD_55) begin
          step_ok   = 1'b1;
          step_next = ST_ERA3;
        end
      end
      ST_ERA3: begin
        // Sector erase takes the sector address; chip erase must hit 555.
        if (cpu_data_in == CMD_SECT || (at_555 && cpu_data_in == CMD_CHIP)) begin
          step_ok   = 1'b1;
          step_next = ST_BUSY;
        end
      end
      default: begin
        step_ok   = 1'b0;
        step_next = ST_IDLE;
      end
    endcase
  end

  // Zero-latency permission. It is valid in the same cycle as the write it
  // qualifies, so it can gate flash_we directly.
  assign flash_we_allow = prg_write_enabled & ~reset & rom_wr & (step_ok | cmd_f0);

`ifdef FLASH_SEQ_TIMEOUT_EN
  localparam logic [6:0] TIMEOUT_LAST = 7'(TIMEOUT_CYCLES - 1);

  logic [6:0] idle_cnt;
  logic       in_partial;

  assign in_partial  = (state != ST_IDLE) && (state != ST_BUSY);
  assign timeout_hit = in_partial && !rom_wr && (idle_cnt == TIMEOUT_LAST);

  // Counts consecutive cycles without a ROM write while a sequence is open.
  always_ff @(posedge m2) begin
    if (reset || !in_partial || rom_wr || timeout_hit) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 7'd1;
    end
  end
`else
  // Without the idle counter a partial sequence never expires. The
  // comparison is constant false for any legal TIMEOUT_CYCLES.
  assign timeout_hit = (TIMEOUT_CYCLES < 1);
`endif

  always_ff @(posedge m2) begin
    if (reset) begin
      state     <= ST_IDLE;
      busy_cnt  <= '0;
      busy      <= 1'b0;
      seq_error <= 1'b0;
    end else if (state == ST_BUSY) begin
      // Writes are ignored here, F0 included. Permission loss does not stop
      // the count either, because the flash is already committed.
      if (busy_cnt == 20'd0) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else begin
        busy_cnt <= busy_cnt - 20'd1;
      end
    end else if (!prg_write_enabled) begin
      state <= ST_IDLE;
    end else if (rom_wr) begin
      if (cmd_f0) begin
        state     <= ST_IDLE;
        seq_error <= 1'b0;
      end else if (step_ok) begin
        state <= step_next;
        if (step_next == ST_BUSY) begin
          busy     <= 1'b1;
          busy_cnt <= (state == ST_PROG) ? PROG_LOAD : ERASE_LOAD;
        end
      end else if (state != ST_IDLE) begin
        // A stray write mid-sequence breaks it. In IDLE the same write is
        // just a mapper-register write and is silently ignored.
        state     <= ST_IDLE;
        seq_error <= 1'b1;
      end
    end else if (timeout_hit) begin
      state <= ST_IDLE;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_flash_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_flash_cmd_sequencer
//
// Scoreboard bench for flash_cmd_sequencer.
//
// The stimulus process drives one bus cycle at a time. For each cycle it asks
// a command-table reference model for the expected allow value and for the
// registered outputs visible during that cycle, and queues the expectation.
// A monitor process pops and compares one expectation every falling edge.
//
// The model keeps the history of accepted writes and matches it against the
// JEDEC command tables. It also keeps the number of busy cycles still owed.
// -----------------------------------------------------------------------------
module tb_flash_cmd_sequencer;

  localparam int PROG_N  = 32;
  localparam int ERASE_N = 100;
`ifdef FLASH_SEQ_TIMEOUT_EN
  localparam int TO_N    = 64;
`endif

  logic        m2 = 1'b0;
  logic        reset;
  logic        romsel;
  logic        cpu_rw_in;
  logic [14:0] cpu_addr_in;
  logic [7:0]  cpu_data_in;
  logic        prg_write_enabled;
  logic        flash_we_allow;
  logic        busy;
  logic        seq_error;
  logic [2:0]  state_dbg;

  always #5 m2 = ~m2;

  flash_cmd_sequencer #(
    .PROG_CYCLES    (PROG_N),
    .ERASE_CYCLES   (ERASE_N),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .m2                (m2),
    .reset             (reset),
    .romsel            (romsel),
    .cpu_rw_in         (cpu_rw_in),
    .cpu_addr_in       (cpu_addr_in),
    .cpu_data_in       (cpu_data_in),
    .prg_write_enabled (prg_write_enabled),
    .flash_we_allow    (flash_we_allow),
    .busy              (busy),
    .seq_error         (seq_error),
    .state_dbg         (state_dbg)
  );

  typedef struct packed {
    logic [11:0] a;
    logic [7:0]  d;
  } wr_t;

  typedef struct packed {
    logic        any_a;
    logic        any_d;
    logic [11:0] a;
    logic [7:0]  d;
  } pat_t;

  typedef struct packed {
    logic       allow;
    logic [2:0] st;
    logic       bsy;
    logic       err;
  } exp_t;

  // Command tables: 0 = program, 1 = sector erase, 2 = chip erase.
  pat_t cmd_tbl [3][6];
  int   cmd_len [3];
  int   cmd_cycles [3];

  exp_t sb_q [$];
  wr_t  hist [$];
  int   busy_rem;
  logic m_err;
`ifdef FLASH_SEQ_TIMEOUT_EN
  int   idle_n;
`endif

  int   total = 0;
  int   bad = 0;
  logic pwe_cur;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic pat_t mk(input logic aa, input logic ad, input logic [11:0] a, input logic [7:0] d);
    pat_t p;
    p.any_a = aa;
    p.any_d = ad;
    p.a     = a;
    p.d     = d;
    return p;
  endfunction

  task automatic init_tables();
    pat_t p_aa, p_55;
    p_aa = mk(1'b0, 1'b0, 12'h555, 8'hAA);
    p_55 = mk(1'b0, 1'b0, 12'h2AA, 8'h55);
    for (int c = 0; c < 3; c++) begin
      cmd_tbl[c][0] = p_aa;
      cmd_tbl[c][1] = p_55;
      cmd_tbl[c][3] = p_aa;
      cmd_tbl[c][4] = p_55;
      cmd_tbl[c][2] = mk(1'b0, 1'b0, 12'h555, 8'h80);
    end
    cmd_tbl[0][2] = mk(1'b0, 1'b0, 12'h555, 8'hA0);
    cmd_tbl[0][3] = mk(1'b1, 1'b1, 12'h000, 8'h00);
    cmd_tbl[0][5] = mk(1'b1, 1'b1, 12'h000, 8'h00);
    cmd_tbl[1][5] = mk(1'b1, 1'b0, 12'h000, 8'h30);
    cmd_tbl[2][5] = mk(1'b0, 1'b0, 12'h555, 8'h10);
    cmd_len[0] = 4;      cmd_cycles[0] = PROG_N;
    cmd_len[1] = 6;      cmd_cycles[1] = ERASE_N;
    cmd_len[2] = 6;      cmd_cycles[2] = ERASE_N;
  endtask

  function automatic bit pat_hit(input pat_t p, input wr_t w);
    return (p.any_a || p.a == w.a) && (p.any_d || p.d == w.d);
  endfunction

  // Index of the command whose accepted prefix equals the history and whose
  // next step is this write, or -1 if no command continues this way.
  function automatic int seq_match(input wr_t w);
    for (int c = 0; c < 3; c++) begin
      bit ok;
      if (hist.size() >= cmd_len[c]) continue;
      ok = 1'b1;
      for (int i = 0; i < hist.size(); i++) begin
        if (!pat_hit(cmd_tbl[c][i], hist[i])) ok = 1'b0;
      end
      if (ok && pat_hit(cmd_tbl[c][hist.size()], w)) return c;
    end
    return -1;
  endfunction

  function automatic logic [2:0] model_state();
    case (hist.size())
      0:       return 3'd0;
      1:       return 3'd1;
      2:       return 3'd2;
      3:       return (hist[2].d == 8'hA0) ? 3'd3 : 3'd4;
      4:       return 3'd5;
      default: return 3'd6;
    endcase
  endfunction

  task automatic model_step(input logic rst, input bit wr, input logic [11:0] a,
                            input logic [7:0] d, input logic p);
    exp_t e;
    wr_t  w;
    int   c;
    w.a = a;
    w.d = d;
    c = -1;
    if (!rst && p && wr && busy_rem == 0 && d != 8'hF0) c = seq_match(w);
    e.st    = (busy_rem > 0) ? 3'd7 : model_state();
    e.bsy   = (busy_rem > 0);
    e.err   = m_err;
    e.allow = !rst && p && wr && busy_rem == 0 && (d == 8'hF0 || c >= 0);
    sb_q.push_back(e);
`ifdef FLASH_SEQ_TIMEOUT_EN
    if (!rst && busy_rem == 0 && p && !wr && hist.size() != 0) begin
      idle_n++;
      if (idle_n == TO_N) begin
        hist.delete();
        idle_n = 0;
      end
    end else begin
      idle_n = 0;
    end
`endif
    if (rst) begin
      hist.delete();
      busy_rem = 0;
      m_err    = 1'b0;
    end else if (busy_rem > 0) begin
      busy_rem--;
    end else if (!p) begin
      hist.delete();
    end else if (wr) begin
      if (d == 8'hF0) begin
        hist.delete();
        m_err = 1'b0;
      end else if (c >= 0) begin
        if (hist.size() + 1 == cmd_len[c]) begin
          hist.delete();
          busy_rem = cmd_cycles[c];
        end else begin
          hist.push_back(w);
        end
      end else if (hist.size() != 0) begin
        hist.delete();
        m_err = 1'b1;
      end
    end
  endtask

  // kind: 0 = no ROM access, 1 = ROM read, 2 = ROM write
  task automatic cyc(input logic rst, input int kind, input logic [14:0] a,
                     input logic [7:0] d, input logic p);
    reset             = rst;
    romsel            = (kind == 0);
    cpu_rw_in         = (kind != 2);
    cpu_addr_in       = a;
    cpu_data_in       = d;
    prg_write_enabled = p;
    model_step(rst, kind == 2, a[11:0], d, p);
    @(posedge m2);
    #1;
  endtask

  task automatic do_wr(input logic [14:0] a, input logic [7:0] d);
    cyc(1'b0, 2, a, d, pwe_cur);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 15'h0, 8'h00, pwe_cur);
  endtask

  task automatic prog_seq(input logic [14:0] a, input logic [7:0] d);
    do_wr(15'h0555, 8'hAA);
    do_wr(15'h02AA, 8'h55);
    do_wr(15'h0555, 8'hA0);
    do_wr(a, d);
  endtask

  task automatic erase_seq(input logic [14:0] a, input logic [7:0] d);
    do_wr(15'h0555, 8'hAA);
    do_wr(15'h02AA, 8'h55);
    do_wr(15'h0555, 8'h80);
    do_wr(15'h0555, 8'hAA);
    do_wr(15'h02AA, 8'h55);
    do_wr(a, d);
  endtask

  // Monitor: one expectation per bus cycle, checked mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge m2);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("allow",     32'(flash_we_allow), 32'(e.allow));
        chk("state_dbg", 32'(state_dbg),      32'(e.st));
        chk("busy",      32'(busy),           32'(e.bsy));
        chk("seq_error", 32'(seq_error),      32'(e.err));
      end
    end
  end

  initial begin
    init_tables();
    busy_rem = 0;
    m_err    = 1'b0;
`ifdef FLASH_SEQ_TIMEOUT_EN
    idle_n   = 0;
`endif
    pwe_cur           = 1'b1;
    reset             = 1'b1;
    romsel            = 1'b1;
    cpu_rw_in         = 1'b1;
    cpu_addr_in       = '0;
    cpu_data_in       = '0;
    prg_write_enabled = 1'b1;
    @(posedge m2);
    #1;
    cyc(1'b1, 0, 15'h0, 8'h00, 1'b1);

    // Program a byte, then sit out the busy window.
    prog_seq(15'h1123, 8'h3C);
    idle(PROG_N + 4);

    // Sector erase at $A000.
    erase_seq(15'h2000, 8'h30);
    idle(ERASE_N + 4);

    // A mapper write in IDLE is ignored.
    do_wr(15'h0000, 8'h07);
    idle(2);

    // Broken sequence, then F0 recovery.
    do_wr(15'h0555, 8'hAA);
    do_wr(15'h0000, 8'h12);
    do_wr(15'h0000, 8'hF0);
    idle(2);

    // Without write permission nothing advances.
    pwe_cur = 1'b0;
    prog_seq(15'h1123, 8'h3C);
    idle(2);
    pwe_cur = 1'b1;

    // Reset in the middle of a program busy window.
    prog_seq(15'h0100, 8'h55);
    idle(10);
    cyc(1'b1, 0, 15'h0, 8'h00, 1'b1);
    idle(3);

    // Open sequence left idle (times out only with the feature enabled).
    do_wr(15'h0555, 8'hAA);
    idle(70);
    do_wr(15'h0000, 8'hF0);

    // Chip erase; writes (F0 too) and reads during busy are ignored.
    erase_seq(15'h4555, 8'h10);
    do_wr(15'h0000, 8'hF0);
    cyc(1'b0, 1, 15'h0000, 8'h00, 1'b1);
    pwe_cur = 1'b0;
    idle(5);
    pwe_cur = 1'b1;
    idle(ERASE_N);

    // Randomized traffic biased towards command bytes.
    for (int n = 0; n < 3000; n++) begin
      int          r;
      logic [14:0] a;
      logic [7:0]  d;
      logic        rst;
      r   = int'($urandom_range(0, 15));
      a   = 15'($urandom);
      d   = 8'($urandom);
      rst = ($urandom_range(0, 299) == 0);
      pwe_cur = ($urandom_range(0, 24) != 0);
      case (r)
        0, 1: cyc(rst, 0, a, d, pwe_cur);
        2:    cyc(rst, 1, a, d, pwe_cur);
        3, 4: cyc(rst, 2, {a[14:12], 12'h555}, 8'hAA, pwe_cur);
        5, 6: cyc(rst, 2, {a[14:12], 12'h2AA}, 8'h55, pwe_cur);
        7:    cyc(rst, 2, {a[14:12], 12'h555}, 8'hA0, pwe_cur);
        8:    cyc(rst, 2, {a[14:12], 12'h555}, 8'h80, pwe_cur);
        9:    cyc(rst, 2, a, 8'h30, pwe_cur);
        10:   cyc(rst, 2, {a[14:12], 12'h555}, 8'h10, pwe_cur);
        11:   cyc(rst, 2, a, 8'hF0, pwe_cur);
        12:   cyc(rst, 2, {a[14:12], 12'h2AA}, 8'hAA, pwe_cur);
        default: cyc(rst, 2, a, d, pwe_cur);
      endcase
    end
    pwe_cur = 1'b1;
    idle(ERASE_N + 2);

    @(negedge m2);
    #1;
    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
